// File: rtl/cgra_writeback_engine.sv
// rtl/cgra_writeback_engine.sv - CGRA result-line writer: buffers lines, issues c1 WrLines, writes DSM completion
//
// Purpose: accepts 512-bit result lines from cgra_shell, queues them in a FIFO, issues one c1 WrLine
//   per line to buf_base+index, counts write responses, then writes a completion line to dsm_base.
// Optional feature macro: CGRA_WB_WRFENCE_EN (issue a WrFence after the last data write, then DSM
//   write without draining; DONE then waits for DSM response and zero outstanding writes).
// Ports:
//   i_clk, i_reset               clock, synchronous active-high reset
//   i_start                      1-cycle pulse, latches i_buf_base/i_dsm_base/i_line_count (IDLE/DONE only)
//   i_data_in, i_valid_in        result line stream, no backpressure
//   i_c1_tx_alm_full             c1 request channel almost full
//   i_c1_rx_*                    c1 write responses (rsp_valid, resp_type, mdata)
//   o_c1_tx_*                    registered c1 write request fields
//   o_busy, o_done, o_fifo_ovf   job status; o_fifo_ovf is sticky until next start
//   o_lines_written              acknowledged data lines this job
module cgra_writeback_engine #(
  parameter int FIFO_DEPTH      = 64,
  parameter int MAX_OUTSTANDING = 32,
  parameter int CNT_W           = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [41:0]      i_buf_base,
  input  logic [41:0]      i_dsm_base,
  input  logic [CNT_W-1:0] i_line_count,
  input  logic [511:0]     i_data_in,
  input  logic             i_valid_in,
  input  logic             i_c1_tx_alm_full,
  input  logic             i_c1_rx_rsp_valid,
  input  logic [3:0]       i_c1_rx_resp_type,
  input  logic [15:0]      i_c1_rx_mdata,
  output logic             o_c1_tx_valid,
  output logic [3:0]       o_c1_tx_req_type,
  output logic [1:0]       o_c1_tx_vc_sel,
  output logic [1:0]       o_c1_tx_cl_len,
  output logic             o_c1_tx_sop,
  output logic [41:0]      o_c1_tx_address,
  output logic [15:0]      o_c1_tx_mdata,
  output logic [511:0]     o_c1_tx_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_fifo_ovf,
  output logic [CNT_W-1:0] o_lines_written
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [3:0]  REQ_WRLINE_I = 4'h0;
  localparam logic [3:0]  RSP_WRLINE   = 4'h0;
  localparam logic [15:0] DSM_MDATA    = 16'hFFFF;
`ifdef CGRA_WB_WRFENCE_EN
  localparam logic [3:0]  REQ_WRFENCE  = 4'h4;
  localparam logic [15:0] FENCE_MDATA  = 16'hFFFE;
`endif

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_FENCE, S_DSM, S_DSM_WAIT, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [41:0]      r_buf_base, r_dsm_base;
  logic [CNT_W-1:0] r_line_count, r_issued, r_enqueued, r_lines_written;
  logic [OUT_W-1:0] r_outstanding, w_out_nxt;
  logic             r_fifo_ovf;
  logic [511:0]     r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]   r_wr_ptr, r_rd_ptr;
  logic             r_tx_valid;
  logic [3:0]       r_tx_req_type;
  logic [41:0]      r_tx_address;
  logic [15:0]      r_tx_mdata;
  logic [511:0]     r_tx_data;
`ifdef CGRA_WB_WRFENCE_EN
  logic             r_dsm_acked;
`endif

  logic w_busy, w_issue_data, w_issue_fence, w_issue_dsm;
  logic w_fifo_empty, w_fifo_full, w_start, w_accept, w_enq, w_ovf;
  logic w_rsp_data, w_rsp_dsm;
  logic [511:0] w_dsm_data;

  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                        (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_start  = i_start && (r_state == S_IDLE || r_state == S_DONE);
  // Lines beyond line_count or outside RUN are dropped; a full FIFO drop does not consume a slot.
  assign w_accept = i_valid_in && (r_state == S_RUN) && (r_enqueued < r_line_count);
  assign w_enq    = w_accept && !w_fifo_full;
  assign w_ovf    = w_accept && w_fifo_full;
  // Fence responses carry a different resp_type and so fall through both decodes.
  assign w_rsp_data = w_busy && i_c1_rx_rsp_valid && (i_c1_rx_resp_type == RSP_WRLINE) &&
                      (i_c1_rx_mdata != DSM_MDATA);
  assign w_rsp_dsm  = (r_state == S_DSM_WAIT) && i_c1_rx_rsp_valid &&
                      (i_c1_rx_resp_type == RSP_WRLINE) && (i_c1_rx_mdata == DSM_MDATA);

  always_comb begin
    w_out_nxt = r_outstanding;
    if (w_issue_data && !w_rsp_data)      w_out_nxt = r_outstanding + OUT_W'(1);
    else if (!w_issue_data && w_rsp_data) w_out_nxt = r_outstanding - OUT_W'(1);
  end

  always_comb begin
    w_dsm_data        = '0;
    w_dsm_data[31:0]  = 32'h1;
    w_dsm_data[63:32] = 32'(r_lines_written);
    w_dsm_data[64]    = r_fifo_ovf;
  end

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (i_start) w_state_nxt = S_RUN;
`ifdef CGRA_WB_WRFENCE_EN
      S_RUN:      if (r_issued == r_line_count) w_state_nxt = S_FENCE;
`else
      S_RUN:      if (r_issued == r_line_count && r_outstanding == '0) w_state_nxt = S_DSM;
`endif
      S_FENCE:    if (w_issue_fence) w_state_nxt = S_DSM;
      S_DSM:      if (w_issue_dsm) w_state_nxt = S_DSM_WAIT;
`ifdef CGRA_WB_WRFENCE_EN
      S_DSM_WAIT: if ((r_dsm_acked || w_rsp_dsm) && w_out_nxt == '0) w_state_nxt = S_DONE;
`else
      S_DSM_WAIT: if (w_rsp_dsm) w_state_nxt = S_DONE;
`endif
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_busy        = 1'b0;
    w_issue_data  = 1'b0;
    w_issue_fence = 1'b0;
    w_issue_dsm   = 1'b0;
    unique case (r_state)
      S_RUN: begin
        w_busy       = 1'b1;
        w_issue_data = !w_fifo_empty && !i_c1_tx_alm_full &&
                       (r_outstanding < OUT_W'(MAX_OUTSTANDING));
      end
      S_FENCE: begin
        w_busy        = 1'b1;
        w_issue_fence = !i_c1_tx_alm_full;
      end
      S_DSM: begin
        w_busy      = 1'b1;
        w_issue_dsm = !i_c1_tx_alm_full;
      end
      S_DSM_WAIT: w_busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_enq) r_fifo_mem[r_wr_ptr[PTR_W-1:0]] <= i_data_in;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_buf_base      <= '0;
      r_dsm_base      <= '0;
      r_line_count    <= '0;
      r_issued        <= '0;
      r_enqueued      <= '0;
      r_lines_written <= '0;
      r_outstanding   <= '0;
      r_fifo_ovf      <= 1'b0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_tx_valid      <= 1'b0;
      r_tx_req_type   <= '0;
      r_tx_address    <= '0;
      r_tx_mdata      <= '0;
      r_tx_data       <= '0;
`ifdef CGRA_WB_WRFENCE_EN
      r_dsm_acked     <= 1'b0;
`endif
    end else begin
      if (w_start) begin
        r_buf_base      <= i_buf_base;
        r_dsm_base      <= i_dsm_base;
        r_line_count    <= i_line_count;
        r_issued        <= '0;
        r_enqueued      <= '0;
        r_lines_written <= '0;
        r_fifo_ovf      <= 1'b0;
`ifdef CGRA_WB_WRFENCE_EN
        r_dsm_acked     <= 1'b0;
`endif
      end
      if (w_enq) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_enqueued <= r_enqueued + 1'b1;
      end
      if (w_ovf) r_fifo_ovf <= 1'b1;
      if (w_issue_data) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_issued <= r_issued + 1'b1;
      end
      r_outstanding <= w_out_nxt;
      if (w_rsp_data) r_lines_written <= r_lines_written + 1'b1;
`ifdef CGRA_WB_WRFENCE_EN
      if (w_rsp_dsm) r_dsm_acked <= 1'b1;
`endif
      r_tx_valid <= w_issue_data || w_issue_fence || w_issue_dsm;
      if (w_issue_data) begin
        r_tx_req_type <= REQ_WRLINE_I;
        r_tx_address  <= r_buf_base + 42'(r_issued);
        r_tx_mdata    <= r_issued[15:0];
        r_tx_data     <= r_fifo_mem[r_rd_ptr[PTR_W-1:0]];
`ifdef CGRA_WB_WRFENCE_EN
      end else if (w_issue_fence) begin
        r_tx_req_type <= REQ_WRFENCE;
        r_tx_address  <= '0;
        r_tx_mdata    <= FENCE_MDATA;
        r_tx_data     <= '0;
`endif
      end else if (w_issue_dsm) begin
        r_tx_req_type <= REQ_WRLINE_I;
        r_tx_address  <= r_dsm_base;
        r_tx_mdata    <= DSM_MDATA;
        r_tx_data     <= w_dsm_data;
      end
    end
  end

  assign o_c1_tx_valid    = r_tx_valid;
  assign o_c1_tx_req_type = r_tx_req_type;
  assign o_c1_tx_vc_sel   = 2'b00;
  assign o_c1_tx_cl_len   = 2'b00;
  assign o_c1_tx_sop      = 1'b1;
  assign o_c1_tx_address  = r_tx_address;
  assign o_c1_tx_mdata    = r_tx_mdata;
  assign o_c1_tx_data     = r_tx_data;
  assign o_busy           = w_busy;
  assign o_done           = (r_state == S_DONE);
  assign o_fifo_ovf       = r_fifo_ovf;
  assign o_lines_written  = r_lines_written;
endmodule
